iq_issue_ctrl: RTL and testbench

IQ_ISSUE_CTRL -- requirements
Module: iq_issue_ctrl

---
 rtl/iq_issue_ctrl.sv | 129 ++++++++++++
 tb/tb_iq_issue_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/iq_issue_ctrl.sv
// Issue-queue control: allocates dispatched instructions into free entries, tracks relative
// age of entries, and issues the oldest operand-ready entry through a one-deep output register.
module iq_issue_ctrl #(
    parameter int IQ_SIZE = 4,
    parameter int WORD_W  = 32,
    parameter int IDX_W   = $clog2(IQ_SIZE)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             flush,
    input  logic                             enq_valid_i,
    output logic                             enq_ready_o,
    input  logic [WORD_W-1:0]                enq_static_i,
    input  logic [IQ_SIZE-1:0]               entry_valid_i,
    input  logic [IQ_SIZE-1:0]               entry_ready_i,
    input  logic [IQ_SIZE-1:0][WORD_W-1:0]   entry_static_i,
    output logic [IQ_SIZE-1:0]               update_o,
    output logic [WORD_W-1:0]                static_o,
    output logic [IQ_SIZE-1:0]               sel_o,
    output logic                             issue_valid_o,
    input  logic                             issue_ready_i,
    output logic [WORD_W-1:0]                issue_static_o,
    output logic [IDX_W-1:0]                 issue_idx_o
);

    // Isolates the lowest set bit; also guarantees one-hot even if ages were ever inconsistent.
    function automatic logic [IQ_SIZE-1:0] lowest_one(input logic [IQ_SIZE-1:0] v);
        return v & (~v + {{(IQ_SIZE-1){1'b0}}, 1'b1});
    endfunction

    logic [IQ_SIZE-1:0]              free_s;
    logic                            alloc_s;
    logic [IQ_SIZE-1:0]              cand_s;
    logic [IQ_SIZE-1:0]              oldest_s;
    logic [IQ_SIZE-1:0]              sel_oh_s;
    logic [IDX_W-1:0]                sel_idx_s;
    logic [WORD_W-1:0]               sel_data_s;
    logic                            can_issue_s;
    logic [IQ_SIZE-1:0][IQ_SIZE-1:0] age_r;

    assign free_s      = ~entry_valid_i;
    assign enq_ready_o = (|free_s) & ~flush & ~rst;
    assign alloc_s     = enq_valid_i & enq_ready_o;
    assign static_o    = enq_static_i;
    assign cand_s      = entry_valid_i & entry_ready_i;
    assign can_issue_s = ~issue_valid_o | issue_ready_i;

    // Allocation strobe: lowest-index free entry only.
    always_comb begin
        update_o = '0;
        if (alloc_s) begin
            update_o = lowest_one(free_s);
        end else begin
            update_o = '0;
        end
    end

    // Oldest-candidate search: entry i wins if it is older than every other candidate.
    always_comb begin
        oldest_s = '0;
        for (int i = 0; i < IQ_SIZE; i++) begin
            oldest_s[i] = cand_s[i];
            for (int j = 0; j < IQ_SIZE; j++) begin
                oldest_s[i] = oldest_s[i] & ((i == j) | ~cand_s[j] | age_r[i][j]);
            end
        end
        sel_oh_s = lowest_one(oldest_s);
    end

    // One-hot to index and payload mux for the selected entry.
    always_comb begin
        sel_idx_s  = '0;
        sel_data_s = '0;
        for (int i = 0; i < IQ_SIZE; i++) begin
            sel_idx_s  = sel_idx_s  | ({IDX_W{sel_oh_s[i]}} & IDX_W'(i));
            sel_data_s = sel_data_s | ({WORD_W{sel_oh_s[i]}} & entry_static_i[i]);
        end
    end

    // Select strobe: flush clears every valid entry; a stall suppresses issue selection.
    always_comb begin
        sel_o = '0;
        if (rst) begin
            sel_o = '0;
        end else if (flush) begin
            sel_o = entry_valid_i;
        end else if (can_issue_s) begin
            sel_o = sel_oh_s;
        end else begin
            sel_o = '0;
        end
    end

    // Age matrix: a newly allocated entry is younger than everyone else.
    always_ff @(posedge clk) begin
        if (rst) begin
            age_r <= '0;
        end else begin
            for (int k = 0; k < IQ_SIZE; k++) begin
                if (update_o[k]) begin
                    age_r[k] <= '0;
                    for (int i = 0; i < IQ_SIZE; i++) begin
                        if (i != k) begin
                            age_r[i][k] <= 1'b1;
                        end
                    end
                end
            end
        end
    end

    // Issue output register: loads when empty or draining, holds on stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            issue_valid_o  <= 1'b0;
            issue_static_o <= '0;
            issue_idx_o    <= '0;
        end else if (flush) begin
            issue_valid_o  <= 1'b0;
        end else if (can_issue_s) begin
            issue_valid_o  <= |cand_s;
            if (|cand_s) begin
                issue_static_o <= sel_data_s;
                issue_idx_o    <= sel_idx_s;
            end
        end
    end

endmodule

// File: tb/tb_iq_issue_ctrl.sv
// Self-checking bench for iq_issue_ctrl: a behavioural entry array answers the strobes and a
// scoreboard of expected issues is compared against every issue-port handshake.
module tb_iq_issue_ctrl;

    localparam int N = 4;
    localparam int W = 32;

    typedef struct {
        logic [1:0]   idx;
        logic [W-1:0] stat;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              flush;
    logic              enq_valid;
    logic              enq_ready;
    logic [W-1:0]      enq_static;
    logic [N-1:0]      ent_valid;
    logic [N-1:0]      ent_ready;
    logic [N-1:0][W-1:0] ent_static;
    logic [N-1:0]      update;
    logic [W-1:0]      static_bc;
    logic [N-1:0]      sel;
    logic              issue_valid;
    logic              issue_ready;
    logic [W-1:0]      issue_static;
    logic [1:0]        issue_idx;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_err    = 0;

    iq_issue_ctrl #(.IQ_SIZE(N), .WORD_W(W)) dut (
        .clk            (clk),
        .rst            (rst),
        .flush          (flush),
        .enq_valid_i    (enq_valid),
        .enq_ready_o    (enq_ready),
        .enq_static_i   (enq_static),
        .entry_valid_i  (ent_valid),
        .entry_ready_i  (ent_ready),
        .entry_static_i (ent_static),
        .update_o       (update),
        .static_o       (static_bc),
        .sel_o          (sel),
        .issue_valid_o  (issue_valid),
        .issue_ready_i  (issue_ready),
        .issue_static_o (issue_static),
        .issue_idx_o    (issue_idx)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic push_exp(input int idx, input logic [W-1:0] stat);
        exp_t e;
        e.idx  = 2'(idx);
        e.stat = stat;
        exp_q.push_back(e);
    endtask

    // One clock: sample strobes and handshake before the edge, then update the entry model.
    task automatic tick();
        logic [N-1:0] upd_v;
        logic [N-1:0] sel_v;
        logic [W-1:0] data_v;
        logic         rst_v;
        exp_t         e;
        @(negedge clk);
        upd_v  = update;
        sel_v  = sel;
        data_v = static_bc;
        rst_v  = rst;
        if (issue_valid && issue_ready && !flush && !rst) begin
            check_val("issue_expected", W'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check_val("issue_idx", W'(issue_idx), W'(e.idx));
                check_val("issue_static", issue_static, e.stat);
            end
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < N; k++) begin
            if (rst_v || sel_v[k]) begin
                ent_valid[k] = 1'b0;
                ent_ready[k] = 1'b0;
            end
            if (upd_v[k]) begin
                ent_valid[k]  = 1'b1;
                ent_ready[k]  = 1'b0;
                ent_static[k] = data_v;
            end
        end
    endtask

    task automatic enq(input logic [W-1:0] stat);
        enq_valid  = 1'b1;
        enq_static = stat;
        tick();
        enq_valid  = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; flush = 1'b0; enq_valid = 1'b0; enq_static = '0;
        ent_valid = '0; ent_ready = '0; ent_static = '0; issue_ready = 1'b1;
        tick();
        #1;
        check_val("rst_sel", W'(sel), 32'd0);
        check_val("rst_update", W'(update), 32'd0);
        check_val("rst_enq_ready", W'(enq_ready), 32'd0);
        tick();
        check_val("rst_issue_valid", W'(issue_valid), 32'd0);
        check_val("rst_issue_idx", W'(issue_idx), 32'd0);
        check_val("rst_issue_static", issue_static, 32'd0);
        rst = 1'b0;

        // Consecutive enqueues fill entries from the bottom up.
        for (int i = 0; i < N; i++) begin
            enq_valid  = 1'b1;
            enq_static = 32'hA000_0000 + W'(i);
            #1;
            check_val("enq_update", W'(update), W'(4'b0001 << i));
            check_val("enq_ready", W'(enq_ready), 32'd1);
            check_val("static_bcast", static_bc, 32'hA000_0000 + W'(i));
            tick();
        end
        #1;
        check_val("full_enq_ready", W'(enq_ready), 32'd0);
        check_val("full_update", W'(update), 32'd0);
        enq_valid = 1'b0;

        // All ready at once: issue in allocation order, one per cycle, latency one.
        for (int i = 0; i < N; i++) push_exp(i, 32'hA000_0000 + W'(i));
        ent_ready = 4'b1111;
        tick();
        check_val("latency_valid", W'(issue_valid), 32'd1);
        check_val("latency_idx", W'(issue_idx), 32'd0);
        for (int i = 0; i < 5; i++) tick();
        check_val("drain_valid", W'(issue_valid), 32'd0);
        check_val("drain_q", W'(exp_q.size()), 32'd0);

        // Allocation order 2,0,1 via reallocation of issued entries.
        enq(32'hB0); enq(32'hB1); enq(32'hB2);
        push_exp(0, 32'hB0); push_exp(1, 32'hB1);
        ent_ready[0] = 1'b1; ent_ready[1] = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        enq(32'hC0); enq(32'hC1);
        push_exp(2, 32'hB2); push_exp(0, 32'hC0); push_exp(1, 32'hC1);
        ent_ready = 4'b0111;
        for (int i = 0; i < 5; i++) tick();
        check_val("order_q", W'(exp_q.size()), 32'd0);

        // Stall for three cycles with a further candidate pending.
        issue_ready = 1'b0;
        enq(32'hD0); enq(32'hD1);
        push_exp(0, 32'hD0); push_exp(1, 32'hD1);
        ent_ready = 4'b0011;
        tick();
        for (int i = 0; i < 3; i++) begin
            #1;
            check_val("stall_sel", W'(sel), 32'd0);
            check_val("stall_valid", W'(issue_valid), 32'd1);
            check_val("stall_idx", W'(issue_idx), 32'd0);
            check_val("stall_static", issue_static, 32'hD0);
            tick();
        end
        issue_ready = 1'b1;
        #1;
        check_val("unstall_sel", W'(sel), 32'd2);
        for (int i = 0; i < 3; i++) tick();
        check_val("stall_q", W'(exp_q.size()), 32'd0);

        // Flush with entries 1011 valid and a held issue.
        enq(32'hE0); enq(32'hE1); enq(32'hE2); enq(32'hE3);
        issue_ready = 1'b0;
        ent_ready[2] = 1'b1;
        tick();
        check_val("pre_flush_valid", W'(issue_valid), 32'd1);
        flush = 1'b1; enq_valid = 1'b1;
        #1;
        check_val("flush_sel", W'(sel), 32'hB);
        check_val("flush_update", W'(update), 32'd0);
        check_val("flush_enq_ready", W'(enq_ready), 32'd0);
        tick();
        flush = 1'b0; enq_valid = 1'b0;
        check_val("post_flush_valid", W'(issue_valid), 32'd0);

        // Reset while stalled drops the held instruction; next enq goes to entry 0.
        enq(32'hF0); enq(32'hF1);
        ent_ready = 4'b0011;
        tick();
        check_val("pre_rst_valid", W'(issue_valid), 32'd1);
        rst = 1'b1; enq_valid = 1'b1;
        #1;
        check_val("rst_mid_sel", W'(sel), 32'd0);
        check_val("rst_mid_update", W'(update), 32'd0);
        check_val("rst_mid_enq_ready", W'(enq_ready), 32'd0);
        tick();
        rst = 1'b0;
        check_val("post_rst_valid", W'(issue_valid), 32'd0);
        check_val("post_rst_idx", W'(issue_idx), 32'd0);
        check_val("post_rst_static", issue_static, 32'd0);
        enq_static = 32'h77;
        #1;
        check_val("post_rst_update", W'(update), 32'd1);
        tick();
        enq_valid = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
